ntt_stage_sequencer: RTL and testbench

Control FSM sitting directly upstream of the zeta address decoder in the 8-butterfly-unit NTT core. On a start command, it walks the seven Kyber layers for a 256-coefficient polynomial: len = 128→2 for a forward NTT, or 2→128 for an inverse NTT. For each layer it issues 16 beats of 8 butterflies to the BU array. Between layers it inserts a pipeline drain gap. It drives the len and is_NTT inputs of the zeta decoder and holds them stable for the whole layer.

---
 rtl/ntt_stage_sequencer.sv | 156 +++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sequencer.sv
// Layer/beat sequencer for the 8-BU Kyber NTT core: walks seven layers of
// BEATS_PER_STAGE beats each and drives len/is_NTT to the zeta address decoder.
module ntt_stage_sequencer #(
  parameter int unsigned BEATS_PER_STAGE = 16,
  parameter int unsigned DRAIN_CYCLES    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               mode_ntt,
  input  logic                               abort,
  input  logic                               issue_ready,
  output logic [7:0]                         len,
  output logic                               is_NTT,
  output logic [2:0]                         stage_idx,
  output logic [$clog2(BEATS_PER_STAGE)-1:0] beat_idx,
  output logic                               issue_valid,
  output logic                               last_beat,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned BW = $clog2(BEATS_PER_STAGE);
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS_PER_STAGE - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [2:0]    STAGE_LAST = 3'd6;
  localparam logic [7:0]    LEN_NTT0   = 8'd128;
  localparam logic [7:0]    LEN_INTT0  = 8'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_len, w_len_nxt;
  logic            r_is_ntt, w_is_ntt_nxt;
  logic [2:0]      r_stage, w_stage_nxt;
  logic [BW-1:0]   r_beat, w_beat_nxt;
  logic [DW-1:0]   r_drain, w_drain_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_last, w_last_nxt;
  logic            r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_is_ntt <= 1'b0;
      r_stage  <= '0;
      r_beat   <= '0;
      r_drain  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_is_ntt <= w_is_ntt_nxt;
      r_stage  <= w_stage_nxt;
      r_beat   <= w_beat_nxt;
      r_drain  <= w_drain_nxt;
      r_valid  <= w_valid_nxt;
      r_last   <= w_last_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_is_ntt_nxt = r_is_ntt;
    w_stage_nxt  = r_stage;
    w_beat_nxt   = r_beat;
    w_drain_nxt  = r_drain;
    w_valid_nxt  = r_valid;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_ISSUE;
          w_is_ntt_nxt = mode_ntt;
          w_len_nxt    = mode_ntt ? LEN_NTT0 : LEN_INTT0;
          w_stage_nxt  = '0;
          w_beat_nxt   = '0;
          w_valid_nxt  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          if (r_beat == BEAT_LAST) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = '0;
            w_valid_nxt = 1'b0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            // len moves only here, so it is already stable on the first beat
            w_state_nxt = S_ISSUE;
            w_stage_nxt = r_stage + 3'd1;
            w_beat_nxt  = '0;
            w_len_nxt   = r_is_ntt ? (r_len >> 1) : (r_len << 1);
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_drain_nxt = r_drain + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt  = S_IDLE;
        w_len_nxt    = '0;
        w_is_ntt_nxt = 1'b0;
        w_stage_nxt  = '0;
        w_beat_nxt   = '0;
        w_drain_nxt  = '0;
        w_valid_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_len_nxt    = '0;
      w_is_ntt_nxt = 1'b0;
      w_stage_nxt  = '0;
      w_beat_nxt   = '0;
      w_drain_nxt  = '0;
      w_valid_nxt  = 1'b0;
      w_done_nxt   = 1'b0;
    end

    w_last_nxt = w_valid_nxt && (w_beat_nxt == BEAT_LAST);
  end

  assign len         = r_len;
  assign is_NTT      = r_is_ntt;
  assign stage_idx   = r_stage;
  assign beat_idx    = r_beat;
  assign issue_valid = r_valid;
  assign last_beat   = r_last;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: schedule-level model compared every cycle,
// plus directed runs with hand-computed cycle and len expectations.
module tb_ntt_stage_sequencer;
  localparam int BEATS = 16;
  localparam int DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode_ntt = 1'b0;
  logic       abort = 1'b0;
  logic       issue_ready = 1'b1;
  logic [7:0] len;
  logic       is_NTT;
  logic [2:0] stage_idx;
  logic [3:0] beat_idx;
  logic       issue_valid, last_beat, busy, done;

  ntt_stage_sequencer #(.BEATS_PER_STAGE(BEATS), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_ntt(mode_ntt), .abort(abort),
    .issue_ready(issue_ready), .len(len), .is_NTT(is_NTT), .stage_idx(stage_idx),
    .beat_idx(beat_idx), .issue_valid(issue_valid), .last_beat(last_beat),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dut_beats = 0;
  int done_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Schedule model: a run is seven layers of BEATS accepted beats each,
  // separated by DRAIN idle cycles, then one done cycle.
  bit m_live = 0, m_run = 0, m_done = 0, m_mode = 0;
  int m_layer = 0, m_acc = 0, m_gap = 0;

  function automatic void m_clear();
    m_run = 0; m_done = 0; m_mode = 0; m_layer = 0; m_acc = 0; m_gap = 0;
  endfunction

  always @(posedge clk) begin
    if (issue_valid === 1'b1 && issue_ready) dut_beats++;
    if (done === 1'b1) done_pulses++;
    if (rst) begin
      m_live = 1;
      m_clear();
    end else if (abort) begin
      m_clear();
    end else if (m_done) begin
      m_clear();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_mode = mode_ntt; m_layer = 0; m_acc = 0; m_gap = 0;
      end
    end else if (m_gap == 0) begin
      if (issue_ready) begin
        m_acc++;
        if (m_acc == BEATS) m_gap = DRAIN;
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        if (m_layer == 6) begin
          m_run = 0; m_done = 1;
        end else begin
          m_layer++; m_acc = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      automatic bit e_busy = m_run || m_done;
      automatic bit e_iv = m_run && (m_gap == 0);
      automatic int e_len = !e_busy ? 0 : (m_mode ? (128 >> m_layer) : (2 << m_layer));
      automatic int e_beat = !e_busy ? 0 : ((m_acc == BEATS) ? BEATS - 1 : m_acc);
      chk("busy", busy, e_busy);
      chk("issue_valid", issue_valid, e_iv);
      chk("len", len, e_len);
      chk("is_NTT", is_NTT, e_busy ? m_mode : 1'b0);
      chk("stage_idx", stage_idx, e_busy ? m_layer : 0);
      chk("beat_idx", beat_idx, e_beat);
      chk("last_beat", last_beat, e_iv && (e_beat == BEATS - 1));
      chk("done", done, m_done);
    end
  end

  task automatic run_to_done(input string name, input int exp_cyc);
    while (done !== 1'b1 && cyc < 1000) step();
    chk({name, "_done_cycle"}, cyc, exp_cyc);
  endtask

  initial begin
    int stalls, icnt, p, found;
    logic [15:0] saved;
    bit stalled;

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_len", len, 0);
    chk("reset_valid", issue_valid, 0);
    rst = 0;
    step();

    // forward NTT, no backpressure
    dut_beats = 0;
    start = 1; mode_ntt = 1; cyc = 0; step(); start = 0;
    chk("ntt_len_c1", len, 128);
    while (done !== 1'b1 && cyc < 1000) begin
      step();
      if (cyc == 61) chk("ntt_len_c61", len, 16);
      if (cyc == 121) chk("ntt_len_c121", len, 2);
    end
    chk("ntt_done_cycle", cyc, 141);
    chk("ntt_beats", dut_beats, 112);
    step();
    chk("ntt_idle_c142", busy, 0);

    // inverse NTT, mode_ntt flipped after the start cycle
    start = 1; mode_ntt = 0; cyc = 0; step(); start = 0; mode_ntt = 1;
    chk("intt_len_c1", len, 2);
    while (done !== 1'b1 && cyc < 1000) begin
      step();
      if (cyc == 121) chk("intt_len_c121", len, 128);
    end
    chk("intt_done_cycle", cyc, 141);
    step();

    // backpressure: every 3rd ISSUE cycle stalls
    dut_beats = 0; stalls = 0; icnt = 0;
    start = 1; mode_ntt = 1; cyc = 0; step(); start = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      stalled = 0;
      if (issue_valid === 1'b1) begin
        icnt++;
        issue_ready = (icnt % 3 != 0);
        if (!issue_ready) begin
          stalls++; stalled = 1;
          saved = {len, stage_idx, beat_idx, issue_valid};
        end
      end else begin
        issue_ready = cyc[0];
      end
      step();
      if (stalled) chk("stall_hold", {len, stage_idx, beat_idx, issue_valid}, saved);
    end
    issue_ready = 1;
    chk("bp_done_cycle", cyc, 141 + stalls);
    chk("bp_beats", dut_beats, 112);
    step();

    // start while busy and in the DONE cycle is ignored
    p = done_pulses;
    start = 1; mode_ntt = 1; cyc = 0; step(); start = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      start = (cyc == 50 || cyc == 138); mode_ntt = 0;
      step();
      start = 0;
      if (cyc == 51) begin
        chk("busy_start_is_ntt", is_NTT, 1);
        chk("busy_start_len", len, 32);
      end
    end
    chk("busy_start_done_cycle", cyc, 141);
    start = 1; step(); start = 0;
    chk("done_cycle_start_ignored", busy, 0);
    chk("single_done_pulse", done_pulses - p, 1);
    start = 1; mode_ntt = 0; cyc = 0; step(); start = 0;
    chk("fresh_run_busy", busy, 1);
    chk("fresh_run_len", len, 2);
    run_to_done("fresh_run", 141);
    step();

    // abort at layer 3 beat 7
    start = 1; mode_ntt = 1; cyc = 0; step(); start = 0;
    found = 0;
    while (!found && cyc < 500) begin
      if (stage_idx == 3 && beat_idx == 7 && issue_valid === 1'b1) found = 1;
      else step();
    end
    chk("abort_point_reached", found, 1);
    chk("abort_point_cycle", cyc, 68);
    p = done_pulses;
    abort = 1; step(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_len", len, 0);
    repeat (200) step();
    chk("abort_no_done", done_pulses - p, 0);
    abort = 1; start = 1; step(); abort = 0; start = 0;
    chk("abort_over_start", busy, 0);
    start = 1; mode_ntt = 1; cyc = 0; step(); start = 0;
    chk("restart_stage", stage_idx, 0);
    chk("restart_len", len, 128);
    run_to_done("restart", 141);
    step();

    // reset mid-DRAIN while mode_ntt toggles
    start = 1; mode_ntt = 1; cyc = 0; step(); start = 0;
    found = 0;
    while (!found && cyc < 500) begin
      if (stage_idx == 2 && busy === 1'b1 && issue_valid === 1'b0) found = 1;
      else begin
        mode_ntt = ~mode_ntt;
        step();
      end
    end
    chk("drain_point_reached", found, 1);
    chk("drain_len", len, 32);
    chk("drain_is_ntt", is_NTT, 1);
    rst = 1; step(); rst = 0;
    chk("rst_outputs", {len, is_NTT, stage_idx, beat_idx, issue_valid, last_beat, busy, done}, 0);
    step();
    chk("rst_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
